ff_frame_packer: RTL and testbench

- Parametrised frame assembler in the ff_clk domain, fed by the demodulator.
- Packs DATA_W-bit beats, prefixed by a frame ID, into a ring of NUM_BUF frame banks.
- Streams completed frames out as LSB-first nibbles over a valid/ready interface, for the MII transmit path (via a separate clock-crossing FIFO).
- Replaces the fixed 1-bit, 2-bank packing with configurable width, depth and bank count, plus overflow detection.

---
 rtl/ff_frame_packer.sv | 180 ++++++++++++++++++
 tb/tb_ff_frame_packer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_frame_packer.sv
// Frame assembler: packs DATA_W-bit beats behind a frame ID into a ring of NUM_BUF banks
// and streams completed frames out as LSB-first nibbles. Define FRAME_PACK_EXT_FRAMEID_EN for an external frame ID.
module ff_frame_packer #(
    parameter int DATA_W       = 1,
    parameter int PAYLOAD_BITS = 64,
    parameter int FRAMEID_W    = 8,
    parameter int NUM_BUF      = 2
) (
    input  logic                       ff_clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       ff_en,
    input  logic [DATA_W-1:0]          ff_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_data,
    output logic                       out_last,
    output logic [$clog2(NUM_BUF):0]   frames_pending,
    output logic                       overflow
`ifdef FRAME_PACK_EXT_FRAMEID_EN
    ,
    input  logic [FRAMEID_W-1:0]       frameid_in
`endif
);

    localparam int FRAME_BITS = FRAMEID_W + PAYLOAD_BITS;
    localparam int NUM_NIBS   = FRAME_BITS / 4;
    localparam int NUM_BEATS  = PAYLOAD_BITS / DATA_W;
    localparam int PTR_W      = $clog2(NUM_BUF);
    localparam int CNT_W      = PTR_W + 1;
    localparam int BEAT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int NIB_W      = (NUM_NIBS > 1) ? $clog2(NUM_NIBS) : 1;
    localparam int OFF_W      = $clog2(FRAME_BITS) + 1;

    if (!(DATA_W == 1 || DATA_W == 2 || DATA_W == 4 || DATA_W == 8)) begin : g_bad_data_w
        $error("ff_frame_packer: DATA_W must be 1, 2, 4 or 8");
    end
    if ((FRAME_BITS % 4) != 0 || (PAYLOAD_BITS % DATA_W) != 0) begin : g_bad_frame
        $error("ff_frame_packer: frame must be nibble aligned and payload beat aligned");
    end
    if (NUM_BUF < 2 || (NUM_BUF & (NUM_BUF - 1)) != 0) begin : g_bad_num_buf
        $error("ff_frame_packer: NUM_BUF must be a power of 2, at least 2");
    end

    typedef enum logic {
        RD_IDLE,
        RD_SEND
    } rd_state_t;

    logic [FRAME_BITS-1:0] bank [NUM_BUF];

    logic [BEAT_W-1:0]    wr_cnt;
    logic [PTR_W-1:0]     wr_ptr;
    logic                 wr_done_p1;
    logic [PTR_W-1:0]     rd_ptr;
    logic [NIB_W-1:0]     rd_nib;
    logic [NIB_W-1:0]     rd_nib_nxt;
    rd_state_t            rd_state;
    logic [FRAMEID_W-1:0] cur_id;

    logic                 beat_req;
    logic                 beat_acc;
    logic                 beat_last;
    logic                 bank_full;
    logic                 rd_done;
    logic [CNT_W:0]       in_flight;
    logic [OFF_W-1:0]     wr_off;
    logic [OFF_W-1:0]     rd_off;

    // A frame finishing this cycle is not yet in frames_pending, so count it
    // here too; otherwise the following beat could land in the bank being read.
    always_comb begin
        in_flight  = {1'b0, frames_pending} + {{CNT_W{1'b0}}, wr_done_p1};
        bank_full  = (in_flight >= (CNT_W + 1)'(NUM_BUF));
        beat_req   = ff_en & start;
        beat_acc   = beat_req & ~bank_full;
        beat_last  = (wr_cnt == BEAT_W'(NUM_BEATS - 1));
        wr_off     = OFF_W'(FRAMEID_W) + OFF_W'(wr_cnt) * OFF_W'(DATA_W);
        rd_nib_nxt = rd_nib + NIB_W'(1);
        rd_off     = OFF_W'(rd_nib_nxt) << 2;
        rd_done    = (rd_state == RD_SEND) & out_ready & out_last;
    end

`ifdef FRAME_PACK_EXT_FRAMEID_EN
    assign cur_id = frameid_in;
`else
    logic [FRAMEID_W-1:0] id_cnt;

    always_ff @(posedge ff_clk) begin
        if (reset) begin
            id_cnt <= '0;
        end else if (beat_acc && beat_last) begin
            id_cnt <= id_cnt + FRAMEID_W'(1);
        end
    end

    assign cur_id = id_cnt;
`endif

    // Bank storage carries no reset; the frame ID rides in with the first beat.
    always_ff @(posedge ff_clk) begin
        if (beat_acc && !reset) begin
            bank[wr_ptr][wr_off +: DATA_W] <= ff_data;
            if (wr_cnt == '0) begin
                bank[wr_ptr][FRAMEID_W-1:0] <= cur_id;
            end
        end
    end

    always_ff @(posedge ff_clk) begin
        if (reset) begin
            wr_cnt     <= '0;
            wr_ptr     <= '0;
            wr_done_p1 <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_done_p1 <= beat_acc & beat_last;
            if (beat_acc) begin
                if (beat_last) begin
                    wr_cnt <= '0;
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end else begin
                    wr_cnt <= wr_cnt + BEAT_W'(1);
                end
            end
            if (beat_req && bank_full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge ff_clk) begin
        if (reset) begin
            frames_pending <= '0;
        end else begin
            frames_pending <= frames_pending + CNT_W'(wr_done_p1) - CNT_W'(rd_done);
        end
    end

    // Read FSM: outputs are registered and only move on a handshake, so they
    // hold steady through a stall.
    always_ff @(posedge ff_clk) begin
        if (reset) begin
            rd_state  <= RD_IDLE;
            rd_ptr    <= '0;
            rd_nib    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (frames_pending != '0) begin
                        rd_nib    <= '0;
                        out_valid <= 1'b1;
                        out_data  <= bank[rd_ptr][3:0];
                        out_last  <= (NUM_NIBS == 1);
                        rd_state  <= RD_SEND;
                    end
                end
                RD_SEND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            rd_ptr    <= rd_ptr + PTR_W'(1);
                            rd_state  <= RD_IDLE;
                        end else begin
                            rd_nib   <= rd_nib_nxt;
                            out_data <= bank[rd_ptr][rd_off +: 4];
                            out_last <= (rd_nib_nxt == NIB_W'(NUM_NIBS - 1));
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ff_frame_packer.sv
// Directed bench for ff_frame_packer at default parameters; a negedge monitor logs every nibble handshake.
module tb_ff_frame_packer;

    logic       ff_clk = 1'b0;
    logic       reset;
    logic       start;
    logic       ff_en;
    logic [0:0] ff_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_last;
    logic [1:0] frames_pending;
    logic       overflow;
`ifdef FRAME_PACK_EXT_FRAMEID_EN
    logic [7:0] frameid_in;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0] nib_q[$];
    bit         last_q[$];

    always #5 ff_clk = ~ff_clk;

    ff_frame_packer dut (
        .ff_clk         (ff_clk),
        .reset          (reset),
        .start          (start),
        .ff_en          (ff_en),
        .ff_data        (ff_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .frames_pending (frames_pending),
        .overflow       (overflow)
`ifdef FRAME_PACK_EXT_FRAMEID_EN
        ,
        .frameid_in     (frameid_in)
`endif
    );

    // Inputs change 1 time unit after posedge, so these values are what the next posedge sees.
    always @(negedge ff_clk) begin
        if (!reset && out_valid && out_ready) begin
            nib_q.push_back(out_data);
            last_q.push_back(out_last);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ff_clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        start     = 1'b0;
        ff_en     = 1'b0;
        ff_data   = 1'b0;
        out_ready = 1'b0;
`ifdef FRAME_PACK_EXT_FRAMEID_EN
        frameid_in = 8'h00;
`endif
        tick();
        tick();
        reset = 1'b0;
        nib_q.delete();
        last_q.delete();
    endtask

    task automatic send_beat(input logic b);
        ff_en   = 1'b1;
        ff_data = b;
        tick();
        ff_en   = 1'b0;
    endtask

    task automatic wait_nibs(input int n, input int budget, input string name);
        for (int i = 0; i < budget && nib_q.size() < n; i++) tick();
        n_total++;
        if (nib_q.size() < n)
            $display("FAIL %s wait: got %0d nibbles, required %0d", name, nib_q.size(), n);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_total += 5;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", out_valid); else n_pass++;
        if (out_last !== 1'b0) $display("FAIL reset_last: got %b required 0", out_last); else n_pass++;
        if (out_data !== 4'h0) $display("FAIL reset_data: got %h required 0", out_data); else n_pass++;
        if (frames_pending !== 2'd0) $display("FAIL reset_pending: got %0d required 0", frames_pending); else n_pass++;
        if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b required 0", overflow); else n_pass++;
    endtask

    task automatic test_basic();
        logic [3:0] exp;
        do_reset();
        start = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) send_beat((k % 2) == 0);
        wait_nibs(18, 100, "basic");
        repeat (20) tick();
        n_total++;
        if (nib_q.size() != 18) $display("FAIL basic_count: got %0d required 18", nib_q.size()); else n_pass++;
        for (int i = 0; i < nib_q.size() && i < 18; i++) begin
            exp = (i < 2) ? 4'h0 : 4'h5;
            n_total += 2;
            if (nib_q[i] !== exp) $display("FAIL basic_nib%0d: got %h required %h", i, nib_q[i], exp); else n_pass++;
            if (last_q[i] !== (i == 17)) $display("FAIL basic_last%0d: got %b required %b", i, last_q[i], (i == 17)); else n_pass++;
        end
        n_total++;
        if (frames_pending !== 2'd0) $display("FAIL basic_pending: got %0d required 0", frames_pending); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        int j;
        do_reset();
        start = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 64; k++) send_beat(1'b1);
        for (int k = 0; k < 64; k++) send_beat((k % 2) == 1);
        for (int k = 0; k < 64; k++) send_beat(1'b1);
        tick();
        n_total += 4;
        if (frames_pending !== 2'd2) $display("FAIL b2b_pending_full: got %0d required 2", frames_pending); else n_pass++;
        if (overflow !== 1'b1) $display("FAIL b2b_overflow: got %b required 1", overflow); else n_pass++;
        if (out_valid !== 1'b1) $display("FAIL b2b_valid_held: got %b required 1", out_valid); else n_pass++;
        if (nib_q.size() != 0) $display("FAIL b2b_no_handshake: got %0d required 0", nib_q.size()); else n_pass++;
        out_ready = 1'b1;
        wait_nibs(36, 200, "b2b");
        repeat (40) tick();
        n_total++;
        if (nib_q.size() != 36) $display("FAIL b2b_count: got %0d required 36", nib_q.size()); else n_pass++;
        for (int i = 0; i < nib_q.size() && i < 36; i++) begin
            if (i < 18) begin
                exp = (i < 2) ? 4'h0 : 4'hF;
            end else begin
                j = i - 18;
                exp = (j == 0) ? 4'h1 : (j == 1) ? 4'h0 : 4'hA;
            end
            n_total++;
            if (nib_q[i] !== exp) $display("FAIL b2b_nib%0d: got %h required %h", i, nib_q[i], exp); else n_pass++;
        end
        n_total++;
        if (frames_pending !== 2'd0) $display("FAIL b2b_pending_drained: got %0d required 0", frames_pending); else n_pass++;
        nib_q.delete();
        last_q.delete();
        for (int k = 0; k < 64; k++) send_beat((k % 2) == 0);
        wait_nibs(18, 100, "b2b_next");
        n_total += 3;
        if (nib_q.size() < 2 || nib_q[0] !== 4'h2) $display("FAIL b2b_next_id_lo: got %h required 2", (nib_q.size() > 0) ? nib_q[0] : 4'hx); else n_pass++;
        if (nib_q.size() < 2 || nib_q[1] !== 4'h0) $display("FAIL b2b_next_id_hi: got %h required 0", (nib_q.size() > 1) ? nib_q[1] : 4'hx); else n_pass++;
        if (overflow !== 1'b1) $display("FAIL b2b_overflow_sticky: got %b required 1", overflow); else n_pass++;
    endtask

    task automatic test_start_gap();
        logic [63:0] p;
        logic [3:0]  exp;
        p = 64'hDEAD_BEEF_0123_4567;
        do_reset();
        start = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) send_beat(p[k]);
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            ff_en = 1'b1;
            ff_data = ~p[30];
            tick();
        end
        ff_en = 1'b0;
        n_total++;
        if (nib_q.size() != 0) $display("FAIL gap_no_early_output: got %0d required 0", nib_q.size()); else n_pass++;
        start = 1'b1;
        for (int k = 30; k < 64; k++) send_beat(p[k]);
        wait_nibs(18, 100, "gap");
        repeat (10) tick();
        n_total += 2;
        if (nib_q.size() != 18) $display("FAIL gap_count: got %0d required 18", nib_q.size()); else n_pass++;
        if (overflow !== 1'b0) $display("FAIL gap_overflow: got %b required 0", overflow); else n_pass++;
        for (int i = 0; i < nib_q.size() && i < 18; i++) begin
            exp = (i < 2) ? 4'h0 : p[4*(i-2) +: 4];
            n_total++;
            if (nib_q[i] !== exp) $display("FAIL gap_nib%0d: got %h required %h", i, nib_q[i], exp); else n_pass++;
        end
    endtask

    task automatic test_ready_toggle();
        logic [63:0] p;
        logic [3:0]  exp;
        logic [3:0]  prev_data;
        logic        prev_last;
        bit          stalled;
        p = 64'h0F1E_2D3C_4B5A_6978;
        do_reset();
        start = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 64; k++) send_beat(p[k]);
        stalled = 1'b0;
        prev_data = 4'h0;
        prev_last = 1'b0;
        for (int c = 0; c < 120 && nib_q.size() < 18; c++) begin
            out_ready = ((c % 2) == 0);
            @(negedge ff_clk);
            if (stalled) begin
                n_total += 2;
                if (out_data !== prev_data) $display("FAIL toggle_hold_data: got %h required %h", out_data, prev_data); else n_pass++;
                if (out_last !== prev_last) $display("FAIL toggle_hold_last: got %b required %b", out_last, prev_last); else n_pass++;
            end
            stalled   = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            tick();
        end
        out_ready = 1'b1;
        repeat (10) tick();
        n_total += 2;
        if (nib_q.size() != 18) $display("FAIL toggle_count: got %0d required 18", nib_q.size()); else n_pass++;
        if (frames_pending !== 2'd0) $display("FAIL toggle_pending: got %0d required 0", frames_pending); else n_pass++;
        for (int i = 0; i < nib_q.size() && i < 18; i++) begin
            exp = (i < 2) ? 4'h0 : p[4*(i-2) +: 4];
            n_total++;
            if (nib_q[i] !== exp) $display("FAIL toggle_nib%0d: got %h required %h", i, nib_q[i], exp); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] p;
        logic [3:0]  exp;
        p = 64'h1234_5678_9ABC_DEF0;
        do_reset();
        start = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) send_beat(1'b0);
        wait_nibs(18, 100, "rstmid_pre");
        repeat (5) tick();
        for (int k = 0; k < 20; k++) send_beat(1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nib_q.delete();
        last_q.delete();
        for (int k = 0; k < 64; k++) send_beat(p[k]);
        wait_nibs(18, 100, "rstmid");
        repeat (10) tick();
        n_total += 2;
        if (nib_q.size() != 18) $display("FAIL rstmid_count: got %0d required 18", nib_q.size()); else n_pass++;
        if (overflow !== 1'b0) $display("FAIL rstmid_overflow: got %b required 0", overflow); else n_pass++;
        for (int i = 0; i < nib_q.size() && i < 18; i++) begin
            exp = (i < 2) ? 4'h0 : p[4*(i-2) +: 4];
            n_total++;
            if (nib_q[i] !== exp) $display("FAIL rstmid_nib%0d: got %h required %h", i, nib_q[i], exp); else n_pass++;
        end
    endtask

`ifdef FRAME_PACK_EXT_FRAMEID_EN
    task automatic test_ext_frameid();
        do_reset();
        start = 1'b1;
        out_ready = 1'b1;
        frameid_in = 8'hA5;
        send_beat(1'b1);
        frameid_in = 8'h00;
        for (int k = 1; k < 64; k++) send_beat((k % 2) == 0);
        wait_nibs(18, 100, "extid");
        n_total += 2;
        if (nib_q.size() < 2 || nib_q[0] !== 4'h5) $display("FAIL extid_lo: got %h required 5", (nib_q.size() > 0) ? nib_q[0] : 4'hx); else n_pass++;
        if (nib_q.size() < 2 || nib_q[1] !== 4'hA) $display("FAIL extid_hi: got %h required a", (nib_q.size() > 1) ? nib_q[1] : 4'hx); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_start_gap();
        test_ready_toggle();
        test_reset_mid_frame();
`ifdef FRAME_PACK_EXT_FRAMEID_EN
        test_ext_frameid();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
